// File: rtl/rot_tile_buf_if.sv
// Stream and mode bundle of the rotating tile buffer.
// The master side (upstream/downstream logic) drives the I_* fields; the buffer drives the O_* fields.
interface rot_tile_buf_if #(
    parameter int PIX_W = 8
);
    logic [1:0]       I_RTB_DEGREES;
    logic             I_RTB_DIRECTION;
    logic             I_RTB_IN_VALID;
    logic [PIX_W-1:0] I_RTB_IN_DATA;
    logic             O_RTB_IN_READY;
    logic             O_RTB_OUT_VALID;
    logic [PIX_W-1:0] O_RTB_OUT_DATA;
    logic             O_RTB_OUT_LAST;
    logic             I_RTB_OUT_READY;
    logic             O_RTB_BUSY;
    logic             O_RTB_TILE_DONE;

    modport master (
        output I_RTB_DEGREES, I_RTB_DIRECTION, I_RTB_IN_VALID, I_RTB_IN_DATA, I_RTB_OUT_READY,
        input  O_RTB_IN_READY, O_RTB_OUT_VALID, O_RTB_OUT_DATA, O_RTB_OUT_LAST, O_RTB_BUSY,
               O_RTB_TILE_DONE
    );

    modport slave (
        input  I_RTB_DEGREES, I_RTB_DIRECTION, I_RTB_IN_VALID, I_RTB_IN_DATA, I_RTB_OUT_READY,
        output O_RTB_IN_READY, O_RTB_OUT_VALID, O_RTB_OUT_DATA, O_RTB_OUT_LAST, O_RTB_BUSY,
               O_RTB_TILE_DONE
    );
endinterface

// File: rtl/rot_tile_buf.sv
// Ping-pong tile buffer: writes a TILE x TILE tile in raster order into one bank
// while the other bank is streamed out rotated by the angle latched at that tile's first pixel.
module rot_tile_buf #(
    parameter int PIX_W = 8,
    parameter int TILE  = 4
) (
    input  logic          I_RTB_HCLK,
    input  logic          I_RTB_RESET,
    rot_tile_buf_if.slave bus
);
    localparam int AW    = $clog2(TILE * TILE);
    localparam int HW    = $clog2(TILE);
    localparam int DEPTH = TILE * TILE;
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_PRIME  = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;

    logic          wr_bank_reg;
    logic          rd_bank_reg;
    logic [1:0]    full_reg;
    logic [1:0]    full_next;
    logic [AW-1:0] wr_cnt_reg;
    logic [AW-1:0] rd_idx_reg;
    logic [1:0]    mode_reg [2];
    logic [1:0]    state_reg;
    logic          done_reg;

    logic          in_ready;
    logic          out_valid;
    logic          in_hs;
    logic          out_hs;
    logic          wr_last;
    logic          rd_last;
    logic          rd_en;
    logic [1:0]    eff;
    logic [1:0]    rd_mode;
    logic [AW-1:0] src_idx;
    logic [HW-1:0] oi;
    logic [HW-1:0] oj;
    logic [HW-1:0] sr;
    logic [HW-1:0] sc;
    logic [AW-1:0] rd_addr;
    logic [PIX_W-1:0] rd_data [2];

    // CCW by d is CW by (4-d) mod 4, which is just a 2-bit negate
    assign eff       = bus.I_RTB_DIRECTION ? 2'(2'd0 - bus.I_RTB_DEGREES) : bus.I_RTB_DEGREES;
    assign in_ready  = ~full_reg[wr_bank_reg];
    assign in_hs     = bus.I_RTB_IN_VALID & in_ready;
    assign wr_last   = (wr_cnt_reg == LAST_IDX);
    assign out_valid = (state_reg == ST_STREAM);
    assign out_hs    = out_valid & bus.I_RTB_OUT_READY;
    assign rd_last   = (rd_idx_reg == LAST_IDX);

    // Reads are issued once in PRIME and then only on an accepted beat, so stalls freeze the read register
    assign rd_en   = (state_reg == ST_PRIME) | (out_hs & ~rd_last);
    assign src_idx = (state_reg == ST_PRIME) ? '0 : rd_idx_reg + AW'(1);
    assign rd_mode = mode_reg[rd_bank_reg];
    assign oi      = src_idx[AW-1:HW];
    assign oj      = src_idx[HW-1:0];

    // TILE is a power of two, so T-1-x is the bitwise complement of x
    always_comb begin
        sr = oi;
        sc = oj;
        case (rd_mode)
            2'd1:    begin sr = ~oj; sc = oi;  end
            2'd2:    begin sr = ~oi; sc = ~oj; end
            2'd3:    begin sr = oj;  sc = ~oi; end
            default: begin sr = oi;  sc = oj;  end
        endcase
    end
    assign rd_addr = {sr, sc};

    always_comb begin
        full_next = full_reg;
        if (in_hs && wr_last) full_next[wr_bank_reg] = 1'b1;
        if (out_hs && rd_last) full_next[rd_bank_reg] = 1'b0;
    end

    always_ff @(posedge I_RTB_HCLK) begin
        if (I_RTB_RESET) begin
            wr_bank_reg <= 1'b0;
            wr_cnt_reg  <= '0;
            mode_reg[0] <= 2'd0;
            mode_reg[1] <= 2'd0;
            full_reg    <= 2'b00;
        end else begin
            full_reg <= full_next;
            if (in_hs) begin
                wr_cnt_reg <= wr_cnt_reg + AW'(1);
                if (wr_cnt_reg == '0) mode_reg[wr_bank_reg] <= eff;
                if (wr_last) wr_bank_reg <= ~wr_bank_reg;
            end
        end
    end

    always_ff @(posedge I_RTB_HCLK) begin
        if (I_RTB_RESET) begin
            state_reg   <= ST_IDLE;
            rd_bank_reg <= 1'b0;
            rd_idx_reg  <= '0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (full_reg[rd_bank_reg]) state_reg <= ST_PRIME;
                end
                ST_PRIME: begin
                    state_reg  <= ST_STREAM;
                    rd_idx_reg <= '0;
                end
                ST_STREAM: begin
                    if (out_hs) begin
                        if (rd_last) begin
                            state_reg   <= ST_IDLE;
                            rd_bank_reg <= ~rd_bank_reg;
                            rd_idx_reg  <= '0;
                            done_reg    <= 1'b1;
                        end else begin
                            rd_idx_reg <= rd_idx_reg + AW'(1);
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        logic [PIX_W-1:0] mem [DEPTH];
        logic [PIX_W-1:0] q_reg;

        always_ff @(posedge I_RTB_HCLK) begin
            if (!I_RTB_RESET && in_hs && (wr_bank_reg == 1'(gi)))
                mem[wr_cnt_reg] <= bus.I_RTB_IN_DATA;
        end

        always_ff @(posedge I_RTB_HCLK) begin
            if (I_RTB_RESET)
                q_reg <= '0;
            else if (rd_en && (rd_bank_reg == 1'(gi)))
                q_reg <= mem[rd_addr];
        end

        assign rd_data[gi] = q_reg;
    end

    assign bus.O_RTB_IN_READY  = in_ready;
    assign bus.O_RTB_OUT_VALID = out_valid;
    assign bus.O_RTB_OUT_DATA  = rd_data[rd_bank_reg];
    assign bus.O_RTB_OUT_LAST  = out_valid & rd_last;
    assign bus.O_RTB_BUSY      = (|full_reg) | (wr_cnt_reg != '0) | (state_reg != ST_IDLE);
    assign bus.O_RTB_TILE_DONE = done_reg;
endmodule

// File: tb/tb_rot_tile_buf.sv
// Randomised bench for rot_tile_buf: a tile-level model rotates whole tiles by repeated 90-degree
// turns and predicts every output pixel, handshake availability, busy and tile-done per cycle.
module tb_rot_tile_buf;
    localparam int T  = 4;
    localparam int PW = 8;
    localparam int N  = T * T;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rot_tile_buf_if #(.PIX_W(PW)) bus ();

    rot_tile_buf #(.PIX_W(PW), .TILE(T)) dut (
        .I_RTB_HCLK  (clk),
        .I_RTB_RESET (rst),
        .bus         (bus.slave)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [PW-1:0] in_tile [$];
    logic [PW-1:0] exp_q   [$];
    int            full_q  [$];
    int            in_mode;
    int            out_pos;
    int            last_done;
    bit            done_pend;

    logic [1:0] tile_dg [4];
    logic       tile_dr [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, expv, cyc);
        end
    endtask

    function automatic void clear_model();
        in_tile.delete();
        exp_q.delete();
        full_q.delete();
        out_pos   = 0;
        done_pend = 1'b0;
        last_done = -100;
        in_mode   = 0;
    endfunction

    // Rotates the finished input tile CW by eff quarter turns and queues the expected output
    function automatic void rot_push(input int eff);
        logic [PW-1:0] a [N];
        logic [PW-1:0] b [N];
        for (int k = 0; k < N; k++) a[k] = in_tile[k];
        for (int s = 0; s < eff; s++) begin
            for (int r = 0; r < T; r++)
                for (int c = 0; c < T; c++)
                    b[r*T+c] = a[(T-1-c)*T+r];
            a = b;
        end
        for (int k = 0; k < N; k++) exp_q.push_back(a[k]);
    endfunction

    // Called at a falling edge: check outputs, drive inputs, book handshakes, advance one cycle
    task automatic cycle(input logic iv, input logic [PW-1:0] d, input logic [1:0] dg,
                         input logic dr, input logic ordy, output logic in_hs);
        logic ov_exp;
        logic out_hs;
        int   start;
        start  = 0;
        ov_exp = 1'b0;
        if (full_q.size() > 0) begin
            start  = (full_q[0] > last_done) ? full_q[0] : last_done;
            ov_exp = (cyc >= start + 2);
        end
        chk("out_valid", bus.O_RTB_OUT_VALID, ov_exp);
        chk("in_ready", bus.O_RTB_IN_READY, full_q.size() < 2);
        chk("busy", bus.O_RTB_BUSY, (full_q.size() > 0) || (in_tile.size() > 0));
        chk("tile_done", bus.O_RTB_TILE_DONE, done_pend);
        done_pend = 1'b0;
        if (bus.O_RTB_OUT_VALID && exp_q.size() > 0) begin
            chk("out_data", bus.O_RTB_OUT_DATA, exp_q[0]);
            chk("out_last", bus.O_RTB_OUT_LAST, out_pos == N - 1);
        end

        bus.I_RTB_IN_VALID  = iv;
        bus.I_RTB_IN_DATA   = d;
        bus.I_RTB_DEGREES   = dg;
        bus.I_RTB_DIRECTION = dr;
        bus.I_RTB_OUT_READY = ordy;

        in_hs  = iv && bus.O_RTB_IN_READY;
        out_hs = bus.O_RTB_OUT_VALID && ordy;
        if (in_hs) begin
            if (in_tile.size() == 0) in_mode = dr ? (4 - int'(dg)) % 4 : int'(dg);
            in_tile.push_back(d);
            if (in_tile.size() == N) begin
                rot_push(in_mode);
                full_q.push_back(cyc + 1);
                in_tile.delete();
            end
        end
        if (out_hs && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            out_pos++;
            if (out_pos == N) begin
                out_pos = 0;
                void'(full_q.pop_front());
                last_done = cyc + 1;
                done_pend = 1'b1;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.I_RTB_IN_VALID  = 1'b0;
        bus.I_RTB_OUT_READY = 1'b1;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        chk("rst_out_valid", bus.O_RTB_OUT_VALID, 1'b0);
        chk("rst_in_ready", bus.O_RTB_IN_READY, 1'b1);
        chk("rst_busy", bus.O_RTB_BUSY, 1'b0);
        chk("rst_out_last", bus.O_RTB_OUT_LAST, 1'b0);
        chk("rst_out_data", bus.O_RTB_OUT_DATA, '0);
        chk("rst_tile_done", bus.O_RTB_TILE_DONE, 1'b0);
    endtask

    // rdy_mode: 0 always ready, 1 random, 2 stalled for 40 cycles then random
    task automatic run_traffic(input int npix, input int rdy_mode, input bit seq,
                               input bit mid, input bit gaps);
        int         sent;
        int         budget;
        int         t;
        logic       hs;
        logic       iv;
        logic       ordy;
        logic       dr;
        logic [1:0] dg;
        logic [PW-1:0] d;
        sent   = 0;
        budget = 0;
        while ((sent < npix || exp_q.size() > 0 || in_tile.size() > 0) && budget < 3000) begin
            iv = (sent < npix) && (!gaps || ($urandom_range(0, 3) != 0));
            d  = seq ? PW'(sent % N) : PW'($urandom);
            t  = (sent / N) % 4;
            if (mid && (sent % N) != 0) begin
                dg = 2'($urandom);
                dr = 1'($urandom);
            end else begin
                dg = tile_dg[t];
                dr = tile_dr[t];
            end
            case (rdy_mode)
                0:       ordy = 1'b1;
                1:       ordy = 1'($urandom_range(0, 1));
                default: ordy = (budget < 40) ? 1'b0 : 1'($urandom_range(0, 1));
            endcase
            cycle(iv, d, dg, dr, ordy, hs);
            if (hs) sent++;
            budget++;
        end
        chk("drain_in_budget", budget < 3000, 1'b1);
        cycle(1'b0, '0, 2'd0, 1'b0, 1'b1, hs);
        cycle(1'b0, '0, 2'd0, 1'b0, 1'b1, hs);
    endtask

    initial begin
        logic hs;
        int   got;
        int   b;
        bus.I_RTB_IN_VALID  = 1'b0;
        bus.I_RTB_IN_DATA   = '0;
        bus.I_RTB_DEGREES   = 2'd0;
        bus.I_RTB_DIRECTION = 1'b0;
        bus.I_RTB_OUT_READY = 1'b1;
        clear_model();
        @(negedge clk);
        do_reset();

        // Single tiles with sequential data 0..15 in each rotation flavour
        tile_dg = '{2'd0, 2'd0, 2'd0, 2'd0}; tile_dr = '{1'b0, 1'b0, 1'b0, 1'b0};
        run_traffic(N, 0, 1'b1, 1'b0, 1'b0);
        tile_dg = '{2'd1, 2'd1, 2'd1, 2'd1};
        run_traffic(N, 0, 1'b1, 1'b0, 1'b0);
        tile_dr = '{1'b1, 1'b1, 1'b1, 1'b1};
        run_traffic(N, 0, 1'b1, 1'b0, 1'b0);
        tile_dg = '{2'd3, 2'd3, 2'd3, 2'd3};
        run_traffic(N, 1, 1'b1, 1'b0, 1'b0);
        tile_dg = '{2'd2, 2'd2, 2'd2, 2'd2}; tile_dr = '{1'b0, 1'b0, 1'b0, 1'b0};
        run_traffic(N, 0, 1'b1, 1'b1, 1'b0);

        // Three back-to-back tiles (0, 90 CW, 180) with downstream stalled first, then random
        tile_dg = '{2'd0, 2'd1, 2'd2, 2'd0}; tile_dr = '{1'b0, 1'b0, 1'b0, 1'b0};
        run_traffic(3 * N, 2, 1'b0, 1'b0, 1'b0);

        // Random modes, random input gaps and random backpressure
        for (int k = 0; k < 4; k++) begin
            tile_dg[k] = 2'($urandom);
            tile_dr[k] = 1'($urandom);
        end
        run_traffic(4 * N, 1, 1'b0, 1'b1, 1'b1);

        // Abort a partial tile with reset, then a clean 0-degree tile
        got = 0;
        b   = 0;
        while (got < 7 && b < 100) begin
            cycle(1'b1, PW'($urandom), 2'd1, 1'b0, 1'b1, hs);
            if (hs) got++;
            b++;
        end
        chk("partial_accepted", got, 7);
        @(negedge clk);
        do_reset();
        tile_dg = '{2'd0, 2'd0, 2'd0, 2'd0}; tile_dr = '{1'b0, 1'b0, 1'b0, 1'b0};
        run_traffic(N, 0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
